// File: rtl/round_sequencer_if.sv
// Handshake bundle between the game sequencer and its question generator, display, buzzer and keypad.
// The master drives req/mode/pattern; the slave returns done, the generated answer and keypad digits.
interface round_sequencer_if;
    logic       gen_req;
    logic       gen_done;
    logic [3:0] gen_result;
    logic       disp_req;
    logic [1:0] disp_mode;
    logic       disp_done;
    logic       buz_req;
    logic       buz_win;
    logic       buz_done;
    logic       ans_valid;
    logic [3:0] ans_value;

    modport master (
        output gen_req, disp_req, disp_mode, buz_req, buz_win,
        input  gen_done, gen_result, disp_done, buz_done, ans_valid, ans_value
    );

    modport slave (
        input  gen_req, disp_req, disp_mode, buz_req, buz_win,
        output gen_done, gen_result, disp_done, buz_done, ans_valid, ans_value
    );
endinterface

// File: rtl/round_sequencer.sv
// Calculator-game controller: level select, then per-round generate/show/answer/judge/buzz, then summary.
// Requests are decoded from state and drop the cycle after done; each phase waits on its peer's done.
module round_sequencer #(
    parameter int LEVELS = 3,
    parameter int T_L1   = 25,
    parameter int T_L2   = 20,
    parameter int T_L3   = 15,
    parameter int TW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic                 start_btn,
    input  logic                 level_btn,
    round_sequencer_if.master    bus,
    output logic [1:0]           start_level,
    output logic [2:0]           level,
    output logic [1:0]           score,
    output logic [TW-1:0]        timer,
    output logic                 green,
    output logic                 red,
    output logic                 busy
);
    typedef enum logic [2:0] {
        S_MENU, S_GEN, S_SHOW, S_ANSWER, S_JUDGE, S_BUZZ, S_SUMMARY, S_END
    } state_t;

    localparam logic [2:0]    LVL_MAX = 3'(LEVELS);
    localparam logic [TW-1:0] TL1     = TW'(T_L1);
    localparam logic [TW-1:0] TL2     = TW'(T_L2);
    localparam logic [TW-1:0] TL3     = TW'(T_L3);

    state_t        state, state_nxt;
    logic [3:0]    exp_q;
    logic [3:0]    ans_q;
    logic          ans_seen;
    logic          win_q;
    logic [TW-1:0] timer_nxt;
    logic [TW-1:0] timer_load;

    // Timer only moves on a game tick and floors at zero.
    assign timer_nxt  = (tick_en && timer != '0) ? timer - 1'b1 : timer;
    assign timer_load = (level == 3'd1) ? TL1 : (level == 3'd2) ? TL2 : TL3;
    assign bus.buz_win = win_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_MENU;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.gen_req   = 1'b0;
        bus.disp_req  = 1'b0;
        bus.buz_req   = 1'b0;
        bus.disp_mode = 2'd2;
        busy          = 1'b1;
        case (state)
            S_MENU: begin
                bus.disp_req  = 1'b1;
                bus.disp_mode = 2'd0;
                busy          = 1'b0;
                if (start_btn) state_nxt = S_GEN;
            end
            S_GEN: begin
                bus.gen_req   = 1'b1;
                bus.disp_mode = 2'd1;
                if (bus.gen_done) state_nxt = S_SHOW;
            end
            S_SHOW: begin
                bus.disp_req  = 1'b1;
                bus.disp_mode = 2'd1;
                if (bus.disp_done) state_nxt = S_ANSWER;
            end
            S_ANSWER: begin
                bus.disp_mode = 2'd1;
                if (timer_nxt == '0) state_nxt = S_JUDGE;
            end
            S_JUDGE: state_nxt = S_BUZZ;
            S_BUZZ: begin
                bus.buz_req = 1'b1;
                if (bus.buz_done)
                    state_nxt = (win_q && level < LVL_MAX) ? S_GEN : S_SUMMARY;
            end
            S_SUMMARY: begin
                bus.disp_req  = 1'b1;
                bus.disp_mode = 2'd3;
                if (bus.disp_done) state_nxt = S_END;
            end
            S_END: begin
                bus.disp_mode = 2'd3;
                busy          = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_level <= 2'd1;
            level       <= 3'd1;
            score       <= 2'd0;
            timer       <= '0;
            green       <= 1'b0;
            red         <= 1'b0;
            exp_q       <= 4'd0;
            ans_q       <= 4'd0;
            ans_seen    <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            case (state)
                S_MENU: begin
                    if (start_btn) begin
                        level <= {1'b0, start_level};
                        score <= 2'd0;
                    end else if (level_btn) begin
                        start_level <= (start_level == 2'd3) ? 2'd1 : start_level + 2'd1;
                    end
                end
                S_GEN: begin
                    if (bus.gen_done) begin
                        exp_q <= bus.gen_result;
                        green <= 1'b0;
                        red   <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (bus.disp_done) begin
                        timer    <= timer_load;
                        ans_seen <= 1'b0;
                    end
                end
                S_ANSWER: begin
                    timer <= timer_nxt;
                    // Only the first digit counts, including one arriving on the final tick.
                    if (bus.ans_valid && !ans_seen) begin
                        ans_seen <= 1'b1;
                        ans_q    <= bus.ans_value;
                    end
                end
                S_JUDGE: begin
                    if (ans_seen && ans_q == exp_q) begin
                        green <= 1'b1;
                        win_q <= 1'b1;
                        if (score != 2'd3) score <= score + 2'd1;
                    end else begin
                        red   <= 1'b1;
                        win_q <= 1'b0;
                    end
                end
                S_BUZZ: begin
                    if (bus.buz_done && win_q && level < LVL_MAX) level <= level + 3'd1;
                end
                S_SUMMARY: begin
                    if (bus.disp_done) begin
                        green <= 1'b0;
                        red   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_round_sequencer.sv
// Directed game scenarios against a phase-level model of the calculator game, checked every cycle.
module tb_round_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       start_btn = 1'b0;
    logic       level_btn = 1'b0;
    logic [1:0] start_level;
    logic [2:0] level;
    logic [1:0] score;
    logic [7:0] timer;
    logic       green, red, busy;

    round_sequencer_if bus ();

    round_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .start_btn  (start_btn),
        .level_btn  (level_btn),
        .bus        (bus),
        .start_level(start_level),
        .level      (level),
        .score      (score),
        .timer      (timer),
        .green      (green),
        .red        (red),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game phases as the rules describe them.
    localparam int P_MENU = 0, P_GEN = 1, P_SHOW = 2, P_ANS = 3, P_JUDGE = 4, P_BUZZ = 5, P_SUM = 6, P_END = 7;
    int m_ph, m_sl, m_lv, m_sc, m_tm, m_exp, m_ans;
    bit m_g, m_r, m_win;

    function automatic int window(input int lv);
        int w[3] = '{25, 20, 15};
        return w[(lv > 3 ? 3 : lv) - 1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = P_MENU; m_sl = 1; m_lv = 1; m_sc = 0; m_tm = 0;
            m_g = 0; m_r = 0; m_win = 0; m_ans = -1; m_exp = 0;
        end else begin
            case (m_ph)
                P_MENU:  if (start_btn) begin m_lv = m_sl; m_sc = 0; m_ph = P_GEN; end
                         else if (level_btn) m_sl = m_sl % 3 + 1;
                P_GEN:   if (bus.gen_done) begin m_exp = bus.gen_result; m_g = 0; m_r = 0; m_ph = P_SHOW; end
                P_SHOW:  if (bus.disp_done) begin m_tm = window(m_lv); m_ans = -1; m_ph = P_ANS; end
                P_ANS: begin
                    if (bus.ans_valid && m_ans < 0) m_ans = bus.ans_value;
                    if (tick_en && m_tm > 0) m_tm--;
                    if (m_tm == 0) m_ph = P_JUDGE;
                end
                P_JUDGE: begin
                    m_win = (m_ans == m_exp);
                    if (m_win) begin m_g = 1; m_sc = (m_sc + 1 > 3) ? 3 : m_sc + 1; end
                    else m_r = 1;
                    m_ph = P_BUZZ;
                end
                P_BUZZ:  if (bus.buz_done) begin
                             if (m_win && m_lv < 3) begin m_lv++; m_ph = P_GEN; end
                             else m_ph = P_SUM;
                         end
                P_SUM:   if (bus.disp_done) begin m_g = 0; m_r = 0; m_ph = P_END; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gen_req",  bus.gen_req,  m_ph == P_GEN);
            chk("disp_req", bus.disp_req, m_ph == P_MENU || m_ph == P_SHOW || m_ph == P_SUM);
            chk("buz_req",  bus.buz_req,  m_ph == P_BUZZ);
            chk("busy",     busy,         !(m_ph == P_MENU || m_ph == P_END));
            if (m_ph == P_MENU || m_ph == P_SHOW || m_ph == P_SUM)
                chk("disp_mode", bus.disp_mode, m_ph == P_MENU ? 0 : m_ph == P_SHOW ? 1 : 3);
            if (m_ph == P_BUZZ) chk("buz_win", bus.buz_win, m_win);
            chk("start_level", start_level, m_sl);
            chk("level", level, m_lv);
            chk("score", score, m_sc);
            chk("timer", timer, m_tm);
            chk("green", green, m_g);
            chk("red",   red,   m_r);
        end
    end

    // Hold the current inputs across one rising edge, then drop every pulse.
    task automatic cyc();
        @(negedge clk);
        tick_en = 0; start_btn = 0; level_btn = 0;
        bus.gen_done = 0; bus.disp_done = 0; bus.buz_done = 0; bus.ans_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; cyc(); rst_n = 1;
    endtask

    task automatic answer(input int at_tick, input logic [3:0] val, output int ticks);
        ticks = 0;
        for (int k = 1; k <= 100; k++) begin
            tick_en = 1;
            if (at_tick > 0 && k == at_tick) begin bus.ans_valid = 1; bus.ans_value = val; end
            cyc();
            ticks++;
            if (timer == 0) break;
            if (at_tick > 0 && k == at_tick) begin bus.ans_valid = 1; bus.ans_value = val ^ 4'h1; end
            cyc();
        end
    endtask

    task automatic round(input logic [3:0] res, input int at_tick, input logic [3:0] val,
                         input int exp_ticks, input logic exp_win, input bit finish_buzz);
        int ticks;
        bus.gen_result = res;
        cyc();
        chk("gen_req_hold", bus.gen_req, 1);
        bus.gen_done = 1; cyc();
        bus.disp_done = 1; cyc();
        answer(at_tick, val, ticks);
        chk("answer_ticks", ticks, exp_ticks);
        chk("judge_timer", timer, 0);
        cyc();
        chk("buzz_req", bus.buz_req, 1);
        chk("buzz_win", bus.buz_win, exp_win);
        chk("buzz_green", green, exp_win);
        chk("buzz_red", red, !exp_win);
        if (finish_buzz) begin bus.buz_done = 1; cyc(); end
    endtask

    task automatic summary();
        chk("sum_mode", bus.disp_mode, 3);
        bus.disp_done = 1; cyc();
        cyc();
        chk("end_busy", busy, 0);
        chk("end_lamps", {green, red}, 0);
    endtask

    initial begin
        bus.gen_done = 0; bus.gen_result = 0; bus.disp_done = 0;
        bus.buz_done = 0; bus.ans_valid = 0; bus.ans_value = 0;
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1;
        chk_en = 1;
        chk("rst_start_level", start_level, 1);
        chk("rst_level", level, 1);
        chk("rst_score", score, 0);
        chk("rst_timer", timer, 0);
        chk("rst_reqs", {bus.gen_req, bus.buz_req, green, red}, 0);
        chk("rst_disp", {bus.disp_req, bus.disp_mode}, 3'b100);

        // Start level 3 via two presses; start+level together keeps level 3.
        level_btn = 1; cyc();
        level_btn = 1; cyc();
        chk("sel_level3", start_level, 3);
        start_btn = 1; level_btn = 1; cyc();
        chk("start_sl", start_level, 3);
        chk("start_level", level, 3);
        chk("start_gen_req", bus.gen_req, 1);
        round(4'd9, 3, 4'd9, 15, 1, 1);
        chk("l3_win_score", score, 1);
        summary();

        // Level 1 win then level 2 wrong answer.
        do_reset();
        start_btn = 1; cyc();
        round(4'd7, 5, 4'd7, 25, 1, 1);
        chk("l1_next_level", level, 2);
        chk("l1_score", score, 1);
        round(4'd4, 3, 4'd5, 20, 0, 1);
        chk("l2_fail_score", score, 1);
        summary();
        chk("end_score", score, 1);

        // Timeout with no answer.
        do_reset();
        start_btn = 1; cyc();
        round(4'd2, 0, 4'd0, 25, 0, 1);
        chk("timeout_score", score, 0);
        summary();

        // Three wins; second answer lands on the final tick.
        do_reset();
        start_btn = 1; cyc();
        round(4'd1, 1, 4'd1, 25, 1, 1);
        round(4'd8, 20, 4'd8, 20, 1, 1);
        round(4'd0, 10, 4'd0, 15, 1, 1);
        chk("win3_score", score, 3);
        chk("win3_level", level, 3);
        summary();

        // Reset while the buzzer request is up.
        do_reset();
        start_btn = 1; cyc();
        round(4'd6, 2, 4'd6, 25, 1, 0);
        rst_n = 0; cyc(); rst_n = 1;
        chk("rst_buz_req", bus.buz_req, 0);
        chk("rst_mid_score", score, 0);
        chk("rst_mid_lamps", {green, red}, 0);
        chk("rst_mid_busy", busy, 0);
        cyc();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
